// File: rtl/instruction_fetch_unit_pkg.sv
// Shared MIPS pipeline definitions used by the instruction fetch stage:
// widths, reset/NOP encodings and the fetch FSM state type.
package mips_pkg;

  localparam int unsigned INSTR_WIDTH = 32;
  localparam int unsigned ADDR_WIDTH  = 32;

  localparam logic [INSTR_WIDTH-1:0] NOP_INSTR        = 32'd0;
  localparam logic [ADDR_WIDTH-1:0]  RESET_PC_DEFAULT = 32'd0;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

  // Force a byte address onto a word boundary.
  function automatic logic [ADDR_WIDTH-1:0] word_align(input logic [ADDR_WIDTH-1:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory request bus: the fetch unit drives the byte address and
// the memory returns the instruction word combinationally.
interface instruction_fetch_unit_if;
  import mips_pkg::*;

  logic [ADDR_WIDTH-1:0]  imem_address;
  logic [INSTR_WIDTH-1:0] imem_instruction;

  modport master (output imem_address, input  imem_instruction);
  modport slave  (input  imem_address, output imem_instruction);

endinterface

// File: rtl/instruction_fetch_unit_pc_register.sv
// Program counter register with load enable; the next-PC selection is made
// by the owner and presented on next_pc.
module pc_register
  import mips_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_en,
  input  logic [ADDR_WIDTH-1:0] next_pc,
  output logic [ADDR_WIDTH-1:0] pc
);

  logic [ADDR_WIDTH-1:0] r_pc;

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         r_pc <= RESET_PC;
    else if (load_en) r_pc <= next_pc;
  end

  assign pc = r_pc;

endmodule

// File: rtl/instruction_fetch_unit.sv
// MIPS IF stage: owns the PC, fetches from the combinational instruction
// memory and registers the IF/ID latch, with freeze, redirect and halt.
module instruction_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned            IMEM_WORDS = 74,
  parameter logic [INSTR_WIDTH-1:0] NOP        = NOP_INSTR
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       freeze,
  input  logic                       branch_taken,
  input  logic [ADDR_WIDTH-1:0]      branch_address,
  instruction_fetch_unit_if.master   imem,
  output logic [INSTR_WIDTH-1:0]     if_id_instruction,
  output logic [ADDR_WIDTH-1:0]      if_id_pc,
  output logic                       if_id_valid,
  output logic                       halted
);

  localparam logic [ADDR_WIDTH-1:0] FETCH_LIMIT = ADDR_WIDTH'(IMEM_WORDS) << 2;

  fetch_state_e r_state;
  fetch_state_e w_state_next;

  logic [ADDR_WIDTH-1:0]  w_pc;
  logic [ADDR_WIDTH-1:0]  w_pc_plus4;
  logic [ADDR_WIDTH-1:0]  w_branch_target;
  logic                   w_pc_in_range;
  logic                   w_target_in_range;

  logic                   w_pc_load;
  logic [ADDR_WIDTH-1:0]  w_pc_next;
  logic                   w_ifid_load;
  logic [INSTR_WIDTH-1:0] w_ifid_instr_next;
  logic [ADDR_WIDTH-1:0]  w_ifid_pc_next;
  logic                   w_ifid_valid_next;

  logic [INSTR_WIDTH-1:0] r_ifid_instr;
  logic [ADDR_WIDTH-1:0]  r_ifid_pc;
  logic                   r_ifid_valid;

  assign w_pc_plus4        = w_pc + 32'd4;
  assign w_branch_target   = word_align(branch_address);
  assign w_pc_in_range     = (w_pc < FETCH_LIMIT);
  assign w_target_in_range = (w_branch_target < FETCH_LIMIT);

  pc_register #(
    .RESET_PC (RESET_PC)
  ) u_pc_register (
    .clk     (clk),
    .rst     (rst),
    .load_en (w_pc_load),
    .next_pc (w_pc_next),
    .pc      (w_pc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= RUN;
    else      r_state <= w_state_next;
  end

  // NOTE: every signal assigned in an always_comb gets a default first, so
  // no path through the case leaves it unassigned and infers a latch.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      RUN:  if (!branch_taken && !w_pc_in_range)    w_state_next = HALT;
      HALT: if (branch_taken && w_target_in_range)  w_state_next = RUN;
      default:                                      w_state_next = RUN;
    endcase
  end

  // Out-of-range PC wins over freeze: there is nothing valid to hold for.
  always_comb begin
    w_pc_load         = 1'b0;
    w_pc_next         = w_pc_plus4;
    w_ifid_load       = 1'b0;
    w_ifid_instr_next = NOP;
    w_ifid_pc_next    = '0;
    w_ifid_valid_next = 1'b0;
    case (r_state)
      RUN: begin
        if (branch_taken) begin
          w_pc_load   = 1'b1;
          w_pc_next   = w_branch_target;
          w_ifid_load = 1'b1;
        end else if (!w_pc_in_range) begin
          w_ifid_load = 1'b1;
        end else if (!freeze) begin
          w_pc_load         = 1'b1;
          w_ifid_load       = 1'b1;
          w_ifid_instr_next = imem.imem_instruction;
          w_ifid_pc_next    = w_pc_plus4;
          w_ifid_valid_next = 1'b1;
        end
      end
      HALT: begin
        if (branch_taken) begin
          w_pc_load   = 1'b1;
          w_pc_next   = w_branch_target;
          w_ifid_load = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ifid_instr <= NOP;
      r_ifid_pc    <= '0;
      r_ifid_valid <= 1'b0;
    end else if (w_ifid_load) begin
      r_ifid_instr <= w_ifid_instr_next;
      r_ifid_pc    <= w_ifid_pc_next;
      r_ifid_valid <= w_ifid_valid_next;
    end
  end

  assign imem.imem_address = word_align(w_pc);
  assign if_id_instruction = r_ifid_instr;
  assign if_id_pc          = r_ifid_pc;
  assign if_id_valid       = r_ifid_valid;
  assign halted            = (r_state == HALT);

endmodule
